// File: rtl/dmem_responder.sv
// Data-memory responder: 2^DEPTH_LOG2 x 32 array behind a valid/ready request port with programmable wait states.
// Define DMEM_BYTE_WRITE_EN to honour req_be per byte lane; otherwise every store writes the full word.
module dmem_responder #(
  parameter int WAIT_STATES = 2,
  parameter int DEPTH_LOG2  = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [DEPTH_LOG2-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_be,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t                state;
  logic [3:0]            count;
  logic                  write_q;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;
  logic [3:0]            lane_en;
  logic [31:0]           cur_word;
  logic [31:0]           merged;

  logic [31:0] mem [2**DEPTH_LOG2];

`ifdef DMEM_BYTE_WRITE_EN
  assign lane_en = be_q;
`else
  logic unused_be;
  assign lane_en   = 4'hF;
  assign unused_be = ^be_q;
`endif

  assign cur_word = mem[addr_q];

  always_comb begin
    merged = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // The array has no reset so contents survive a reset; an aborted store never reaches it.
  always_ff @(posedge clock) begin
    if (!reset && state == ACCESS && write_q) mem[addr_q] <= merged;
  end

  // RESP also accepts a new request so a held req_valid sustains one access per WAIT_STATES+2 cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      count      <= 4'd0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (req_valid) begin
            write_q   <= req_write;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            be_q      <= req_be;
            req_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              state <= ACCESS;
            end else begin
              state <= WAIT;
              count <= WAIT_STATES[3:0];
            end
          end else begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count <= 4'd1) state <= ACCESS;
        end
        ACCESS: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          req_ready  <= 1'b1;
          resp_rdata <= write_q ? merged : cur_word;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance with WAIT_STATES=2, one with WAIT_STATES=0, sharing stimulus.
module tb_dmem_responder;

  localparam int WS = 2;
`ifdef DMEM_BYTE_WRITE_EN
  localparam bit BE_ON = 1'b1;
`else
  localparam bit BE_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, resp_valid;
  logic [31:0] resp_rdata;
  logic        ready0, resp0_valid;
  logic [31:0] resp0_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] expq[$];
  logic [31:0] exp0q[$];

  typedef struct packed {
    logic        write;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs[12];

  always #5 clock = ~clock;

  dmem_responder #(.WAIT_STATES(WS), .DEPTH_LOG2(7)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata)
  );

  dmem_responder #(.WAIT_STATES(0), .DEPTH_LOG2(7)) dut0 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .req_ready(ready0), .resp_valid(resp0_valid), .resp_rdata(resp0_rdata)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drives one request into the WAIT_STATES=2 instance and scores its response.
  task automatic applyStimulus(input logic wr, input logic [6:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic [31:0] expected);
    int lat;
    bit found;
    logic [31:0] exp_val;
    @(negedge clock);
    checkOutput("ready_before_req", req_ready, 1'b1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clock);
    expq.push_back(expected);
    @(negedge clock);
    req_valid = 1'b0;
    lat = 0;
    found = 1'b0;
    while (!found && lat <= 20) begin
      if (resp_valid) found = 1'b1;
      else begin
        @(negedge clock);
        lat++;
      end
    end
    exp_val = expq.pop_front();
    checkOutput("latency", found ? lat : 32'hFFFF_FFFF, WS + 1);
    checkOutput("rdata", found ? resp_rdata : 32'hXXXX_XXXX, exp_val);
    @(negedge clock);
    checkOutput("single_pulse", resp_valid, 1'b0);
    checkOutput("rdata_hold", resp_rdata, exp_val);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int low_cnt, hi_cnt, first, seen, acc, nresp, last;

    vecs[0]  = '{1'b1, 7'h7F, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 7'h7F, 32'h0,        4'h0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 7'h7F, 32'h11223344, 4'h5, (BE_ON ? 32'hDE22BE44 : 32'h11223344)};
    vecs[3]  = '{1'b0, 7'h7F, 32'h0,        4'h0, (BE_ON ? 32'hDE22BE44 : 32'h11223344)};
    vecs[4]  = '{1'b1, 7'h00, 32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5};
    vecs[5]  = '{1'b1, 7'h00, 32'hFFFFFFFF, 4'h0, (BE_ON ? 32'hA5A5A5A5 : 32'hFFFFFFFF)};
    vecs[6]  = '{1'b0, 7'h00, 32'h0,        4'h0, (BE_ON ? 32'hA5A5A5A5 : 32'hFFFFFFFF)};
    vecs[7]  = '{1'b1, 7'h01, 32'h00000000, 4'hF, 32'h00000000};
    vecs[8]  = '{1'b1, 7'h01, 32'hCAFEF00D, 4'h8, (BE_ON ? 32'hCA000000 : 32'hCAFEF00D)};
    vecs[9]  = '{1'b1, 7'h10, 32'h12345678, 4'hF, 32'h12345678};
    vecs[10] = '{1'b0, 7'h10, 32'h0,        4'h0, 32'h12345678};
    vecs[11] = '{1'b0, 7'h01, 32'h0,        4'h0, (BE_ON ? 32'hCA000000 : 32'hCAFEF00D)};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("reset_ready", req_ready, 1'b1);
    checkOutput("reset_resp_valid", resp_valid, 1'b0);
    checkOutput("reset_rdata", resp_rdata, 32'h0);
    checkOutput("reset_rdata_ws0", resp0_rdata, 32'h0);

    // Load from 0x05: ready low for WAIT,WAIT,ACCESS and one response pulse after E0+3.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 7'h05;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    low_cnt = 0; hi_cnt = 0; first = -1;
    for (int i = 0; i < 8; i++) begin
      if (!req_ready) low_cnt++;
      if (resp_valid) begin
        hi_cnt++;
        if (first < 0) first = i;
      end
      @(negedge clock);
    end
    checkOutput("load05_ready_low_cycles", low_cnt, 3);
    checkOutput("load05_valid_cycles", hi_cnt, 1);
    checkOutput("load05_valid_edge", first, 3);

    for (int v = 0; v < 12; v++)
      applyStimulus(vecs[v].write, vecs[v].addr, vecs[v].wdata, vecs[v].be, vecs[v].expected);

    // Reset one cycle after accepting a store to 0x10: no response and no write.
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h10; req_wdata = 32'h0000CAFE; req_be = 4'hF;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("abort_ready", req_ready, 1'b1);
    checkOutput("abort_rdata_cleared", resp_rdata, 32'h0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (resp_valid || resp0_valid) seen++;
      @(negedge clock);
    end
    checkOutput("abort_no_resp", seen, 0);
    applyStimulus(1'b0, 7'h10, 32'h0, 4'h0, 32'h12345678);

    // WAIT_STATES=0 instance with req_valid held for three back-to-back loads.
    acc = 0; nresp = 0; last = -1;
    for (int i = 0; i < 12; i++) begin
      if (resp0_valid) begin
        nresp++;
        if (exp0q.size() > 0) checkOutput("b2b_rdata", resp0_rdata, exp0q.pop_front());
        else checkOutput("b2b_unexpected_resp", 1'b1, 1'b0);
        if (last >= 0) checkOutput("b2b_gap", i - last, 2);
        last = i;
      end
      if (acc < 3) begin
        req_valid = 1'b1; req_write = 1'b0; req_addr = 7'h10;
        if (ready0) begin
          acc++;
          exp0q.push_back(32'h12345678);
        end
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clock);
    end
    checkOutput("b2b_resp_count", nresp, 3);
    checkOutput("b2b_queue_empty", exp0q.size(), 0);
    repeat (8) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
